instr_fetch: RTL

Fetch stage sitting directly upstream of the decoder/control unit. Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake. Captures the response into an output register that presents instr, PC and the 7-bit opcode to decode. Handles back-pressure from decode (one-entry skid), plus redirects from branch/jump resolution that kill in-flight fetches.

---
 rtl/instr_fetch.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage feeding the decoder/control unit. Owns the program counter and
// keeps at most one instruction-memory request outstanding. Each returned word
// is captured into an output register that presents the instruction, its PC
// and the 7-bit opcode to decode. Decode back-pressure is absorbed by a
// one-entry skid register. Branch/jump redirects reload the PC and kill any
// fetch still in flight.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_STEP   sequential PC increment (4 for RV32I without compressed)
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   imem_req_valid    request valid to instruction memory
//   imem_req_ready    memory accepts the request
//   imem_addr         request address (always the current PC)
//   imem_rsp_valid    one-cycle response pulse, at most one per accepted request
//   imem_rsp_data     instruction word returned by memory
//   redirect_valid    taken branch/jump, load redirect_pc
//   redirect_pc       redirect target
//   stall             decode cannot accept this cycle
//   if_valid          fetched instruction valid to decode
//   if_pc             PC of if_instr
//   if_instr          instruction word
//   if_opcode         if_instr[6:0]
//   if_misalign       misaligned-redirect flag
//
// Optional feature (macro FETCH_MISALIGN_EN):
//   Defined:   a redirect to a target with non-zero low bits loads the PC, raises
//              if_misalign and halts fetching until an aligned redirect arrives.
//   Undefined: redirect targets have their low two bits forced to zero and
//              if_misalign is tied low.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode,
  output logic        if_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_q, skid_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic [31:0] redir_target;
  logic        halt_q, halt_d;
  logic        can_accept;
  logic        req_fire;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;

  assign redir_target = redirect_pc;

  // The halt flag follows the alignment of the most recent redirect.
  always_comb begin
    halt_d = misalign_q;
    if (redirect_valid) begin
      halt_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= halt_d;
    end
  end

  assign halt_q      = misalign_q;
  assign if_misalign = misalign_q;
`else
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
  assign halt_q       = 1'b0;
  assign halt_d       = 1'b0;
  assign if_misalign  = 1'b0;
`endif

  // The output register can take a new word when it is empty or being drained.
  assign can_accept     = !if_valid_q || !stall;
  assign imem_req_valid = (state_q == ST_REQ) && can_accept;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Next-state and datapath update; every register defaults to holding.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    skid_d     = skid_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    // Decode takes the presented word; loads below re-assert if_valid.
    if (!stall) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!halt_q) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (req_fire) begin
          pc_d     = pc_q + PC_STEP;
          req_pc_d = pc_q;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = halt_q ? ST_IDLE : ST_REQ;
          end else if (can_accept) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rsp_data;
            state_d    = ST_REQ;
          end else begin
            skid_d  = imem_rsp_data;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // req_pc_q still names the skid word: no request was issued since.
        if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = req_pc_q;
          if_instr_d = skid_q;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect overrides everything above. A request that is outstanding, or
    // launched this very cycle, is marked for discard. If its response lands
    // in the same cycle as the redirect it is already complete, so there is
    // nothing left to kill and waiting for another response would deadlock.
    if (redirect_valid) begin
      pc_d       = redir_target;
      if_valid_d = 1'b0;
      if (((state_q == ST_WAIT) && !imem_rsp_valid) ||
          ((state_q == ST_REQ) && req_fire)) begin
        kill_d  = 1'b1;
        state_d = ST_WAIT;
      end else begin
        kill_d  = 1'b0;
        state_d = halt_d ? ST_IDLE : ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      skid_q     <= 32'h0;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      skid_q     <= skid_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_opcode = if_instr_q[6:0];

endmodule
